// File: rtl/ifft_pkg.sv
// Shared definitions for the IFFT_256 datapath and its output reorder stage.
// Holds the frame geometry, sample width, default normalisation shift and
// the read-side FSM state encodings.
package ifft_pkg;

  localparam int IFFT_N     = 256;
  localparam int IFFT_LOG2N = 8;
  localparam int IFFT_W     = 16;
  localparam int IFFT_SHIFT = 8;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_t;

endpackage

// File: rtl/ifft_reorder_ram.sv
// Simple dual-port synchronous RAM used as the ping-pong frame store.
// One write port and one read port. The read data is registered, so it
// appears one cycle after the address. Storage has no reset.
//   clk    : clock, rising edge
//   we     : write enable
//   waddr  : write address ({bank, addr})
//   wdata  : write data ({real, imag})
//   re     : read enable
//   raddr  : read address ({bank, addr})
//   rdata  : registered read data, held while re is low
module ifft_reorder_ram #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ifft256_out_reorder.sv
// Output reorder stage for IFFT_256. Samples arrive in bit-reversed index
// order; each 256-point frame is written into one half of a ping-pong RAM
// at its natural address, then drained in natural order while the next
// frame fills the other half. Output is scaled by 1/2^SHIFT with
// round-half-up.
//   clk       : clock, rising edge
//   rst       : synchronous reset, active-high
//   in_valid  : x_real/x_img carry a sample this cycle
//   x_real    : signed real part from the IFFT
//   x_img     : signed imaginary part from the IFFT
//   y_real    : reordered, scaled real part (0 while out_valid is low)
//   y_img     : reordered, scaled imaginary part (0 while out_valid is low)
//   out_valid : y_* valid this cycle
//   out_last  : last sample (n = N-1) of a frame
//   ovf       : sticky, a sample was dropped because its bank was full
//
// Read FSM
//   state    | meaning
//   RD_IDLE  | no full bank waiting, rcnt held at 0
//   RD_DRAIN | reading bank rbank at address rcnt, one word per cycle
module ifft256_out_reorder
  import ifft_pkg::*;
#(
  parameter int N     = IFFT_N,
  parameter int LOG2N = IFFT_LOG2N,
  parameter int W     = IFFT_W,
  parameter int SHIFT = IFFT_SHIFT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic signed [W-1:0] x_real,
  input  logic signed [W-1:0] x_img,
  output logic signed [W-1:0] y_real,
  output logic signed [W-1:0] y_img,
  output logic                out_valid,
  output logic                out_last,
  output logic                ovf
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam int RND_I   = (SHIFT > 0) ? (1 << RND_POS) : 0;

  logic [LOG2N-1:0] wcnt;
  logic [LOG2N-1:0] wcnt_rev;
  logic             wbank;
  logic             rbank;
  logic [1:0]       full;
  logic [LOG2N-1:0] rcnt;
  logic [LOG2N-1:0] rcnt_n;
  rd_state_t        rd_state;
  rd_state_t        rd_state_n;

  logic             rd_en;
  logic             rd_done;
  logic             bank_release;
  logic             wr_en;
  logic             wr_drop;
  logic             wr_done;
  logic             next_full;

  logic             rd_vld_q;
  logic             rd_last_q;
  logic [2*W-1:0]   ram_rdata;

  // Write counter k lands at natural index bitrev(k).
  for (genvar i = 0; i < LOG2N; i++) begin : g_bitrev
    assign wcnt_rev[i] = wcnt[LOG2N-1-i];
  end

  assign rd_done = (rd_state == RD_DRAIN) && (rcnt == LAST);

  // A bank whose last word is being read this cycle may take the first word
  // of the next frame: that word goes to address 0, never the one being read,
  // and this removes the one-cycle gap between drain start and write start.
  assign bank_release = rd_done && (rbank == wbank);
  assign wr_en        = in_valid && (!full[wbank] || bank_release);
  assign wr_drop      = in_valid && !wr_en;
  assign wr_done      = wr_en && (wcnt == LAST);

  // Other bank full now, or becoming full on this edge.
  assign next_full = full[~rbank] || (wr_done && (wbank != rbank));

  always_comb begin
    rd_state_n = rd_state;
    rcnt_n     = rcnt;
    rd_en      = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        rcnt_n = '0;
        if (full[rbank]) rd_state_n = RD_DRAIN;
      end
      RD_DRAIN: begin
        rd_en  = 1'b1;
        rcnt_n = rcnt + 1'b1;
        if (rd_done && !next_full) rd_state_n = RD_IDLE;
      end
      default: begin
        rd_state_n = RD_IDLE;
        rcnt_n     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      rcnt     <= '0;
    end else begin
      rd_state <= rd_state_n;
      rcnt     <= rcnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt  <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      full  <= 2'b00;
      ovf   <= 1'b0;
    end else begin
      if (wr_en) wcnt <= wcnt + 1'b1;
      if (wr_done) begin
        full[wbank] <= 1'b1;
        wbank       <= ~wbank;
      end
      if (rd_done) begin
        full[rbank] <= 1'b0;
        rbank       <= ~rbank;
      end
      if (wr_drop) ovf <= 1'b1;
    end
  end

  ifft_reorder_ram #(
    .AW(LOG2N + 1),
    .DW(2 * W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr({wbank, wcnt_rev}),
    .wdata({x_real, x_img}),
    .re   (rd_en),
    .raddr({rbank, rcnt}),
    .rdata(ram_rdata)
  );

  // (x + 2^(SHIFT-1)) >>> SHIFT in W+1 bits; the result always fits W bits
  // for SHIFT >= 1, and SHIFT = 0 reduces to a plain copy.
  function automatic logic signed [W-1:0] scale(input logic signed [W-1:0] x);
    logic signed [W:0] ext;
    ext = $signed({x[W-1], x}) + $signed((W+1)'(RND_I));
    ext = ext >>> SHIFT;
    return ext[W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      y_real    <= '0;
      y_img     <= '0;
    end else begin
      rd_vld_q  <= rd_en;
      rd_last_q <= rd_done;
      out_valid <= rd_vld_q;
      out_last  <= rd_last_q;
      if (rd_vld_q) begin
        y_real <= scale(ram_rdata[2*W-1:W]);
        y_img  <= scale(ram_rdata[W-1:0]);
      end else begin
        y_real <= '0;
        y_img  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ifft256_out_reorder.sv
module tb_ifft256_out_reorder;
  import ifft_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [15:0] x_real;
  logic signed [15:0] x_img;
  logic signed [15:0] y_real;
  logic signed [15:0] y_img;
  logic               out_valid;
  logic               out_last;
  logic               ovf;

  int total = 0;
  int bad   = 0;

  logic signed [15:0] cap_r [768];
  logic signed [15:0] cap_i [768];
  logic               cap_v [768];
  logic               cap_l [768];
  time                cap_t0;
  time                feed_end;

  always #5 clk = ~clk;

  ifft256_out_reorder dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .x_real   (x_real),
    .x_img    (x_img),
    .y_real   (y_real),
    .y_img    (y_img),
    .out_valid(out_valid),
    .out_last (out_last),
    .ovf      (ovf)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] brev(input logic [7:0] a);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = a[7-i];
    return b;
  endfunction

  // Low 8 bits of n, sign-extended: the value recovered from (n*256 wrapped
  // to 16 bits) after a rounded shift by 8.
  function automatic logic signed [15:0] s8(input int n);
    logic [7:0] t;
    t = n[7:0];
    return {{8{t[7]}}, t};
  endfunction

  // mode 0: x_real = nat*256, x_img = -nat*256 (wrapped to 16 bits)
  // mode 1: x_real = nat*256, x_img = tag*256
  // mode 2: x_real = x_img = tag
  task automatic feed(input int mode, input int tag, input int duty);
    logic [7:0]         n;
    logic signed [15:0] r;
    logic signed [15:0] im;
    for (int k = 0; k < 256; k++) begin
      if (duty < 100) begin
        while (int'($urandom_range(99)) >= duty) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      n = brev(8'(k));
      case (mode)
        0: begin r = {n, 8'h00}; im = 16'sd0 - r; end
        1: begin r = {n, 8'h00}; im = 16'(tag * 256); end
        default: begin r = 16'(tag); im = 16'(tag); end
      endcase
      x_real = r; x_img = im; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; x_real = '0; x_img = '0;
    feed_end = $time;
  endtask

  task automatic capture(input int nexp, input int tmo);
    int w = 0;
    cap_t0 = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && w < tmo) begin
      w++;
      @(negedge clk);
    end
    if (out_valid === 1'b1) cap_t0 = $time;
    for (int i = 0; i < nexp; i++) begin
      cap_v[i] = out_valid; cap_r[i] = y_real; cap_i[i] = y_img; cap_l[i] = out_last;
      if (i < nexp - 1) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; x_real = '0; x_img = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid, out_last, ovf} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got valid/last/ovf=%b want 000", {out_valid, out_last, ovf});
    end
    total++;
    if (y_real !== 16'sd0 || y_img !== 16'sd0) begin
      bad++; $display("FAIL reset_data: got %0d/%0d want 0/0", y_real, y_img);
    end
  endtask

  task automatic test_single_frame();
    int nv = 0, ed = 0, el = 0;
    feed(0, 0, 100);
    capture(256, 20);
    // last input cycle ends at edge T; first valid is sampled at negedge after T+3
    total++;
    if (cap_t0 - feed_end !== 34) begin
      bad++; $display("FAIL single_latency: got %0d want 34", cap_t0 - feed_end);
    end
    for (int i = 0; i < 256; i++) begin
      if (cap_v[i] === 1'b1) nv++;
      if (cap_r[i] !== s8(i) || cap_i[i] !== s8(-i)) ed++;
      if (cap_l[i] !== (i == 255)) el++;
    end
    total++;
    if (nv !== 256) begin bad++; $display("FAIL single_valid_count: got %0d want 256", nv); end
    total++;
    if (ed !== 0) begin bad++; $display("FAIL single_data: got %0d bad samples want 0", ed); end
    total++;
    if (el !== 0) begin bad++; $display("FAIL single_last: got %0d bad flags want 0", el); end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || y_real !== 16'sd0 || out_last !== 1'b0) begin
      bad++; $display("FAIL single_tail: got valid=%b y=%0d last=%b want 0/0/0", out_valid, y_real, out_last);
    end
  endtask

  task automatic test_back_to_back();
    int nv = 0, ed = 0, el = 0;
    fork
      begin feed(1, 1, 100); feed(1, 11, 100); feed(1, 21, 100); end
      capture(768, 600);
    join
    for (int i = 0; i < 768; i++) begin
      if (cap_v[i] === 1'b1) nv++;
      if (cap_r[i] !== s8(i % 256) || cap_i[i] !== 16'(10 * (i / 256) + 1)) ed++;
      if (cap_l[i] !== ((i % 256) == 255)) el++;
    end
    total++;
    if (nv !== 768) begin bad++; $display("FAIL b2b_no_bubble: got %0d valid cycles want 768", nv); end
    total++;
    if (ed !== 0) begin bad++; $display("FAIL b2b_data: got %0d bad samples want 0", ed); end
    total++;
    if (el !== 0) begin bad++; $display("FAIL b2b_last: got %0d bad flags want 0", el); end
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL b2b_ovf: got %b want 0", ovf); end
    @(negedge clk);
  endtask

  task automatic test_gapped();
    int nv = 0, ed = 0;
    fork
      feed(0, 0, 40);
      capture(256, 3000);
    join
    total++;
    if (cap_t0 - feed_end !== 34) begin
      bad++; $display("FAIL gapped_latency: got %0d want 34", cap_t0 - feed_end);
    end
    for (int i = 0; i < 256; i++) begin
      if (cap_v[i] === 1'b1) nv++;
      if (cap_r[i] !== s8(i) || cap_i[i] !== s8(-i) || cap_l[i] !== (i == 255)) ed++;
    end
    total++;
    if (nv !== 256 || ed !== 0) begin
      bad++; $display("FAIL gapped_data: got valid=%0d bad=%0d want 256/0", nv, ed);
    end
    @(negedge clk);
  endtask

  task automatic test_rounding();
    int vals [6];
    int exps [6];
    vals = '{127, 128, -384, -385, 32767, -32768};
    exps = '{0, 1, -1, -2, 128, -128};
    for (int v = 0; v < 6; v++) begin
      int ed = 0;
      logic signed [15:0] got = '0;
      feed(2, vals[v], 100);
      capture(256, 20);
      for (int i = 0; i < 256; i++) begin
        if (cap_v[i] !== 1'b1 || cap_r[i] !== 16'(exps[v]) || cap_i[i] !== 16'(exps[v])) begin
          if (ed == 0) got = cap_r[i];
          ed++;
        end
      end
      total++;
      if (ed !== 0) begin
        bad++; $display("FAIL round_x%0d: got %0d (%0d bad) want %0d", vals[v], got, ed, exps[v]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_overflow();
    int nv = 0, ed = 0;
    force dut.rd_state = RD_IDLE;
    feed(1, 1, 100);
    feed(1, 2, 100);
    @(negedge clk);
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_before: got %b want 0", ovf); end
    @(posedge clk); #1;
    x_real = 16'sd7; x_img = 16'sd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; x_real = '0; x_img = '0;
    @(negedge clk);
    total++;
    if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_rise: got %b want 1", ovf); end
    repeat (5) @(negedge clk);
    total++;
    if (ovf !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL ovf_hold: got ovf=%b valid=%b want 1/0", ovf, out_valid);
    end
    release dut.rd_state;
    capture(512, 20);
    for (int i = 0; i < 512; i++) begin
      if (cap_v[i] === 1'b1) nv++;
      if (cap_r[i] !== s8(i % 256) || cap_i[i] !== 16'(1 + i / 256)) ed++;
    end
    total++;
    if (nv !== 512 || ed !== 0) begin
      bad++; $display("FAIL ovf_drain_ab: got valid=%0d bad=%0d want 512/0", nv, ed);
    end
    total++;
    if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int quiet = 0, ed = 0;
    force dut.rd_state = RD_IDLE;
    feed(1, 3, 100);
    for (int k = 0; k <= 100; k++) begin
      x_real = {brev(8'(k)), 8'h00}; x_img = 16'sd1024; in_valid = 1'b1;
      if (k == 47) release dut.rd_state;
      if (k == 100) begin
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || y_real !== 16'sd50 || y_img !== 16'sd3) begin
          bad++; $display("FAIL rstmid_align: got valid=%b y=%0d/%0d want 1 50/3", out_valid, y_real, y_img);
        end
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0; x_real = '0; x_img = '0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || y_real !== 16'sd0 || y_img !== 16'sd0 || ovf !== 1'b0) begin
      bad++; $display("FAIL rstmid_clear: got valid=%b y=%0d/%0d ovf=%b want 0 0/0 0", out_valid, y_real, y_img, ovf);
    end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) quiet++;
    end
    total++;
    if (quiet !== 0) begin bad++; $display("FAIL rstmid_quiet: got %0d valid cycles want 0", quiet); end
    @(posedge clk); #1;
    fork
      feed(0, 0, 100);
      capture(256, 1000);
    join
    total++;
    if (cap_t0 - feed_end !== 34) begin
      bad++; $display("FAIL rstmid_latency: got %0d want 34", cap_t0 - feed_end);
    end
    for (int i = 0; i < 256; i++)
      if (cap_v[i] !== 1'b1 || cap_r[i] !== s8(i) || cap_i[i] !== s8(-i) || cap_l[i] !== (i == 255)) ed++;
    total++;
    if (ed !== 0) begin bad++; $display("FAIL rstmid_frame: got %0d bad samples want 0", ed); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gapped();
    test_rounding();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
